// File: rtl/led_seq_ctrl_if.sv
// Control, ROM and LED signal bundle for the LED pattern sequencer.
interface led_seq_ctrl_if;
    logic        start;
    logic        stop;
    logic        dir;
    logic [3:0]  rom_data_r;
    logic [3:0]  rom_data_l;
    logic [11:0] rom_addr;
    logic        rom_en;
    logic        rom_sel;
    logic [3:0]  led;
    logic        busy;
    logic        step_done;

    // Environment side: issues requests, serves ROM data, observes outputs.
    modport master (
        output start, stop, dir, rom_data_r, rom_data_l,
        input  rom_addr, rom_en, rom_sel, led, busy, step_done
    );

    // Sequencer side.
    modport slave (
        input  start, stop, dir, rom_data_r, rom_data_l,
        output rom_addr, rom_en, rom_sel, led, busy, step_done
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: steps through a pattern ROM once every CLK_DIV
// cycles, choosing the shift-right or shift-left ROM per step.
module led_seq_ctrl #(
    parameter int unsigned CLK_DIV  = 50000000,
    parameter logic [11:0] ADDR_MAX = 12'hFFF
) (
    input logic           clk,
    input logic           rst_n,
    led_seq_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    // Last WAIT count value; WAIT spans CLK_DIV-2 cycles so FETCH recurs every CLK_DIV.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 3);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_WAIT    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      addr_q, addr_d;
    logic [3:0]       led_q, led_d;
    logic             sel_q, sel_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             step_q, step_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        led_d   = led_q;
        sel_d   = sel_q;
        step_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = S_FETCH;
                    sel_d   = bus.dir;
                end
            end
            S_FETCH: begin
                state_d = bus.stop ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                // A stop here drops the step entirely: no LED update, no advance.
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    led_d   = sel_q ? bus.rom_data_l : bus.rom_data_r;
                    step_d  = 1'b1;
                    addr_d  = (addr_q == ADDR_MAX) ? 12'd0 : 12'(addr_q + 12'd1);
                end
            end
            S_WAIT: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FETCH;
                    sel_d   = bus.dir;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        en_d   = (state_d == S_FETCH);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= 12'd0;
            led_q   <= 4'h0;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            led_q   <= led_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
        end
    end

    assign bus.rom_addr  = addr_q;
    assign bus.rom_en    = en_q;
    assign bus.rom_sel   = sel_q;
    assign bus.led       = led_q;
    assign bus.busy      = busy_q;
    assign bus.step_done = step_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with CLK_DIV=8, ADDR_MAX=3.
module tb_led_seq_ctrl;

    logic clk;
    logic rst_n;

    led_seq_ctrl_if bus ();

    led_seq_ctrl #(
        .CLK_DIV  (8),
        .ADDR_MAX (12'd3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern ROMs with one-cycle read latency.
    logic [3:0] rom_r [4];
    logic [3:0] rom_l [4];
    initial begin
        rom_r[0] = 4'd8; rom_r[1] = 4'd4; rom_r[2] = 4'd2; rom_r[3] = 4'd1;
        rom_l[0] = 4'd1; rom_l[1] = 4'd2; rom_l[2] = 4'd4; rom_l[3] = 4'd8;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rom_data_r <= 4'h0;
            bus.rom_data_l <= 4'h0;
        end else if (bus.rom_en) begin
            bus.rom_data_r <= rom_r[bus.rom_addr[1:0]];
            bus.rom_data_l <= rom_l[bus.rom_addr[1:0]];
        end
    end

    typedef struct {
        logic        start;
        logic        stop;
        logic        dir;
        logic        en;
        logic [11:0] addr;
        logic        sel;
        logic        busy;
        logic        step;
        logic [3:0]  led;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    function automatic vec_t mk(logic st, logic sp, logic d, logic en, int addr,
                                logic sel, logic busy, logic step, int led);
        vec_t v;
        v.start = st; v.stop = sp; v.dir = d;
        v.en = en; v.addr = 12'(addr); v.sel = sel;
        v.busy = busy; v.step = step; v.led = 4'(led);
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; outputs sampled on the falling edge, step_done drains the scoreboard.
    task automatic tick();
        int e;
        @(posedge clk);
        @(negedge clk);
        if (rst_n && bus.step_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_step_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_led", int'(bus.led), e);
            end
        end
    endtask

    task automatic wait_fetch(int budget);
        int k = 0;
        while (!bus.rom_en && k < budget) begin
            tick();
            k++;
        end
        check("fetch_wait", int'(bus.rom_en), 1);
    endtask

    task automatic wait_drain(int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("sb_drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [12];
        int   seen;
        int   k;
        int   idx;

        vecs[0]  = mk(1, 0, 0, 1, 0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 1, 0, 1, 1, 8);
        vecs[3]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 8);
        vecs[4]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 8);
        vecs[5]  = mk(1, 0, 0, 0, 1, 0, 1, 0, 8);
        vecs[6]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 8);
        vecs[7]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 8);
        vecs[8]  = mk(0, 0, 0, 1, 1, 0, 1, 0, 8);
        vecs[9]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 8);
        vecs[10] = mk(0, 0, 0, 0, 2, 0, 1, 1, 4);
        vecs[11] = mk(0, 0, 0, 0, 2, 0, 1, 0, 4);

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.dir   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("rst_led",  int'(bus.led), 0);
        check("rst_en",   int'(bus.rom_en), 0);
        check("rst_addr", int'(bus.rom_addr), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_sel",  int'(bus.rom_sel), 0);
        check("rst_step", int'(bus.step_done), 0);

        // Start with dir=0; a start pulse mid-WAIT must not disturb the period.
        exp_q.push_back(8);
        exp_q.push_back(4);
        for (int i = 0; i < 12; i++) begin
            bus.start = vecs[i].start;
            bus.stop  = vecs[i].stop;
            bus.dir   = vecs[i].dir;
            tick();
            check($sformatf("v%0d_en", i),   int'(bus.rom_en),    int'(vecs[i].en));
            check($sformatf("v%0d_addr", i), int'(bus.rom_addr),  int'(vecs[i].addr));
            check($sformatf("v%0d_sel", i),  int'(bus.rom_sel),   int'(vecs[i].sel));
            check($sformatf("v%0d_busy", i), int'(bus.busy),      int'(vecs[i].busy));
            check($sformatf("v%0d_step", i), int'(bus.step_done), int'(vecs[i].step));
            check($sformatf("v%0d_led", i),  int'(bus.led),       int'(vecs[i].led));
        end
        bus.start = 1'b0;

        // dir flips to left during WAIT: next fetch uses left ROM at addr 2.
        bus.dir = 1'b1;
        exp_q.push_back(4);
        exp_q.push_back(8);
        wait_fetch(16);
        check("dir_sel",  int'(bus.rom_sel), 1);
        check("dir_addr", int'(bus.rom_addr), 2);
        wait_drain(24);

        // Back to right ROM; address wraps 3 -> 0.
        bus.dir = 1'b0;
        exp_q.push_back(8);
        wait_fetch(16);
        check("wrap_addr", int'(bus.rom_addr), 0);
        check("wrap_sel",  int'(bus.rom_sel), 0);
        wait_drain(16);

        // Stop during CAPTURE of addr 1 drops the step.
        wait_fetch(16);
        check("stopcap_fetch_addr", int'(bus.rom_addr), 1);
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stopcap_busy", int'(bus.busy), 0);
        check("stopcap_led",  int'(bus.led), 8);
        check("stopcap_step", int'(bus.step_done), 0);
        check("stopcap_addr", int'(bus.rom_addr), 1);
        check("stopcap_en",   int'(bus.rom_en), 0);
        repeat (3) tick();
        check("stopcap_idle", int'(bus.busy), 0);

        // Restart resumes at the held address.
        bus.start = 1'b1;
        exp_q.push_back(4);
        tick();
        bus.start = 1'b0;
        check("restart_en",   int'(bus.rom_en), 1);
        check("restart_addr", int'(bus.rom_addr), 1);
        wait_drain(16);

        // Stop in WAIT, then start+stop together in IDLE: stop wins.
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stopwait_busy", int'(bus.busy), 0);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        seen = int'(bus.busy) | int'(bus.rom_en);
        repeat (3) begin
            tick();
            seen = seen | int'(bus.busy) | int'(bus.rom_en);
        end
        check("startstop_no_activity", seen, 0);

        // Asynchronous reset while fetching clears outputs immediately.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("prerst_en",   int'(bus.rom_en), 1);
        check("prerst_addr", int'(bus.rom_addr), 2);
        check("prerst_led",  int'(bus.led), 4);
        rst_n = 1'b0;
        #1;
        check("arst_led",  int'(bus.led), 0);
        check("arst_en",   int'(bus.rom_en), 0);
        check("arst_addr", int'(bus.rom_addr), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_sel",  int'(bus.rom_sel), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_en",   int'(bus.rom_en), 0);
        check("post_rst_led",  int'(bus.led), 0);

        // Full right sequence from address 0 with wrap; one step every 8 cycles.
        exp_q.push_back(8);
        exp_q.push_back(4);
        exp_q.push_back(2);
        exp_q.push_back(1);
        exp_q.push_back(8);
        bus.start = 1'b1;
        k   = 0;
        idx = 0;
        while (idx < 5 && k < 48) begin
            tick();
            bus.start = 1'b0;
            k++;
            if (bus.step_done) begin
                check($sformatf("period_step%0d", idx), k, 3 + 8 * idx);
                idx++;
            end
        end
        check("period_steps", idx, 5);
        check("final_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000000, is the clock cycles per pattern step (0.25 s at 200 MHz); legal minimum 4.
REQ-002 Parameter ADDR_MAX, default 12'hFFF, is the last pattern ROM address before wrap to 0.
REQ-003 clk  input  1  single clock domain, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin stepping.
REQ-006 stop  input  1  single-cycle request to halt stepping.
REQ-007 dir  input  1  pattern select: 0 = shift-right ROM, 1 = shift-left ROM.
REQ-008 rom_data_r  input  4  data from the shift-right pattern ROM.
REQ-009 rom_data_l  input  4  data from the shift-left pattern ROM.
REQ-010 rom_addr  output  12  address shared by both pattern ROMs.
REQ-011 rom_en  output  1  ROM port enable, active high.
REQ-012 rom_sel  output  1  registered copy of dir used for the current step.
REQ-013 led  output  4  registered LED drive.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 step_done  output  1  one-cycle pulse when led is updated.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, CAPTURE and WAIT, and the state SHALL be held in registers.
REQ-017 IDLE -> FETCH on start=1 and stop=0. The FSM SHALL stay in IDLE otherwise.
REQ-018 FETCH SHALL drive rom_en=1 for exactly one cycle with rom_addr stable, and SHALL load rom_sel<=dir at entry.
REQ-019 The FSM SHALL always go FETCH -> CAPTURE. ROM data is valid in CAPTURE, one clock after the enabled edge.
REQ-020 At the end of CAPTURE: led<=rom_data_r if rom_sel=0, else rom_data_l; step_done=1 for that edge only; rom_addr advances.
REQ-021 rom_addr increment SHALL wrap from ADDR_MAX to 0. There is no other address arithmetic.
REQ-022 WAIT SHALL last CLK_DIV-2 cycles and then go to FETCH, so the FETCH-to-FETCH period is exactly CLK_DIV cycles.
REQ-023 The prescaler counter SHALL be ceil(log2(CLK_DIV)) bits wide, cleared on WAIT entry, and SHALL never overflow.
REQ-024 rom_en SHALL be 0 in every state except FETCH.
REQ-025 stop=1 in FETCH, CAPTURE or WAIT -> IDLE on the next edge, with these effects:
- led and rom_addr hold their values;
- no step_done is generated;
- a stop seen in CAPTURE SHALL suppress that led update.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 start=1 and stop=1 in the same cycle: stop wins.
REQ-028 A dir change during a step SHALL NOT affect that step. It takes effect at the next FETCH, and rom_addr continues without reset.
REQ-029 Restarting from IDLE SHALL resume at the held rom_addr. Only reset returns the address to 0.

Reset
REQ-030 rst_n=0 SHALL asynchronously force the following, regardless of state, including mid-WAIT or mid-CAPTURE:
- state=IDLE;
- rom_addr=0, rom_en=0, rom_sel=0;
- led=4'h0;
- busy=0, step_done=0;
- prescaler=0.
REQ-031 After rst_n deasserts, outputs SHALL hold their reset values until start is accepted.

Verification (CLK_DIV=8, ADDR_MAX=3, ROM model: addr0..3 -> 8,4,2,1 right; 1,2,4,8 left, 1-cycle read latency)
REQ-032 Assert rst_n=0 mid-run -> same cycle: led=0, rom_en=0, rom_addr=0, busy=0.
REQ-033 Pulse start with dir=0 ->
- next cycle: rom_en=1, rom_addr=0;
- led=8 with step_done one cycle later;
- FETCH repeats every 8 cycles;
- led sequence 8,4,2,1,8 (address wraps 3->0).
REQ-034 Toggle dir to 1 during WAIT after led=4 -> next FETCH has rom_sel=1, rom_addr=2 and yields led=4 (left ROM); the following step gives 8.
REQ-035 Pulse stop during CAPTURE of addr 1 ->
- led stays 8, no step_done, busy=0 next cycle;
- a later start fetches addr 1.
REQ-036 Assert start and stop together in IDLE -> busy stays 0 and rom_en never rises.
REQ-037 Pulse start while in WAIT -> FETCH period stays 8 cycles with no extra fetch.
